// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared types and constants for the RV32IM execute stage.
//   alu_op_e      : operation codes carried in id_ex_alu_op
//   FWD_*         : forwarding select encodings for forwardA / forwardB
//   div_state_e   : iterative divider FSM states
//   DIV_TAG_W     : width of the {rd, RegWrite, MemRead, MemWrite} bundle
//                   the divider carries alongside an in-flight divide
//   is_div_op()   : true for the four multi-cycle divide/remainder ops
// ----------------------------------------------------------------------------
package ex_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLL    = 5'd2,
      OP_SLT    = 5'd3,
      OP_SLTU   = 5'd4,
      OP_XOR    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_OR     = 5'd8,
      OP_AND    = 5'd9,
      OP_PASSB  = 5'd10,
      OP_MUL    = 5'd11,
      OP_MULH   = 5'd12,
      OP_MULHSU = 5'd13,
      OP_MULHU  = 5'd14,
      OP_DIV    = 5'd15,
      OP_DIVU   = 5'd16,
      OP_REM    = 5'd17,
      OP_REMU   = 5'd18
   } alu_op_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam int DIV_TAG_W = 8;

   function automatic logic is_div_op(input alu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ex_divider.sv
// ----------------------------------------------------------------------------
// ex_divider
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   clk, rst          : clock, synchronous active-high reset
//   i_start           : divide present in EX (acted on only when idle)
//   i_abort           : squash any divide in flight, return to idle
//   i_op, i_a, i_b    : operation and operands, sampled at start
//   i_tag             : {rd, RegWrite, MemRead, MemWrite} carried with the op
//   o_running         : FSM is iterating
//   o_done            : result is valid this cycle (lasts one cycle)
//   o_result, o_tag   : sign-corrected quotient/remainder and its tag
// Divide-by-zero and signed overflow bypass the iteration and go straight
// to DONE with their architected results already in place.
// ----------------------------------------------------------------------------
module ex_divider
   import ex_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DIV_ITER = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  alu_op_e              i_op,
   input  logic [XLEN-1:0]      i_a,
   input  logic [XLEN-1:0]      i_b,
   input  logic [DIV_TAG_W-1:0] i_tag,
   output logic                 o_running,
   output logic                 o_done,
   output logic [XLEN-1:0]      o_result,
   output logic [DIV_TAG_W-1:0] o_tag
);

   localparam logic [5:0] CNT_LAST = 6'(DIV_ITER - 1);

   div_state_e            r_state;
   logic [5:0]            r_cnt;
   logic [XLEN-1:0]       r_divisor;
   logic [XLEN-1:0]       r_quot;      // dividend shifts out the top while quotient bits enter the bottom
   logic [XLEN-1:0]       r_rem;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic                  r_want_rem;
   logic                  r_special;   // result already final, skip sign correction
   logic [DIV_TAG_W-1:0]  r_tag;

   logic                  w_signed;
   logic                  w_a_neg;
   logic                  w_b_neg;
   logic [XLEN-1:0]       w_abs_a;
   logic [XLEN-1:0]       w_abs_b;
   logic                  w_div_zero;
   logic                  w_ovf;
   logic [XLEN:0]         w_shift;
   logic [XLEN:0]         w_diff;
   logic [XLEN-1:0]       w_q_fix;
   logic [XLEN-1:0]       w_r_fix;

   assign w_signed   = (i_op == OP_DIV) || (i_op == OP_REM);
   assign w_a_neg    = w_signed && i_a[XLEN-1];
   assign w_b_neg    = w_signed && i_b[XLEN-1];
   assign w_abs_a    = w_a_neg ? -i_a : i_a;
   assign w_abs_b    = w_b_neg ? -i_b : i_b;
   assign w_div_zero = (i_b == '0);
   assign w_ovf      = w_signed && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);

   // One restoring step: bring down the next dividend bit, try the subtract,
   // keep it only if it did not borrow.
   assign w_shift = {r_rem, r_quot[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_divisor};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= DIV_IDLE;
         r_cnt      <= '0;
         r_divisor  <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_want_rem <= 1'b0;
         r_special  <= 1'b0;
         r_tag      <= '0;
      end else if (i_abort) begin
         r_state <= DIV_IDLE;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (i_start) begin
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_want_rem <= (i_op == OP_REM) || (i_op == OP_REMU);
                  r_tag      <= i_tag;
                  r_divisor  <= w_abs_b;
                  r_cnt      <= CNT_LAST;
                  if (w_div_zero) begin
                     r_quot    <= '1;
                     r_rem     <= i_a;
                     r_special <= 1'b1;
                     r_state   <= DIV_DONE;
                  end else if (w_ovf) begin
                     r_quot    <= i_a;
                     r_rem     <= '0;
                     r_special <= 1'b1;
                     r_state   <= DIV_DONE;
                  end else begin
                     r_quot    <= w_abs_a;
                     r_rem     <= '0;
                     r_special <= 1'b0;
                     r_state   <= DIV_RUN;
                  end
               end
            end
            DIV_RUN: begin
               r_quot <= {r_quot[XLEN-2:0], ~w_diff[XLEN]};
               r_rem  <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
               if (r_cnt == '0) begin
                  r_state <= DIV_DONE;
               end else begin
                  r_cnt <= r_cnt - 6'd1;
               end
            end
            DIV_DONE: begin
               r_state <= DIV_IDLE;
            end
            default: begin
               r_state <= DIV_IDLE;
            end
         endcase
      end
   end

   assign w_q_fix = (!r_special && r_neg_q) ? -r_quot : r_quot;
   assign w_r_fix = (!r_special && r_neg_r) ? -r_rem  : r_rem;

   assign o_running = (r_state == DIV_RUN);
   assign o_done    = (r_state == DIV_DONE);
   assign o_result  = r_want_rem ? w_r_fix : w_q_fix;
   assign o_tag     = r_tag;

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage RV32IM pipeline.
//   clk, rst                         : clock, synchronous active-high reset
//   id_ex_*                          : instruction currently in EX
//   forwardA / forwardB              : operand forwarding selects
//   mem_wb_wdata                     : value being written back in WB
//   flush                            : squash the instruction in EX
//   ex_mem_*                         : EX/MEM pipeline register
//   ex_stall                         : hold IF, ID and ID/EX this cycle
// Single-cycle ALU/MUL ops land in EX/MEM one edge later. Divides hand off
// to ex_divider; the stage stalls until the divider reaches DONE, which is
// the cycle its result enters EX/MEM and ID/EX is allowed to advance.
// ----------------------------------------------------------------------------
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DIV_ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_ex_valid,
   input  logic [XLEN-1:0] id_ex_rs1_data,
   input  logic [XLEN-1:0] id_ex_rs2_data,
   input  logic [XLEN-1:0] id_ex_imm,
   input  logic [4:0]      id_ex_rd,
   input  logic [4:0]      id_ex_alu_op,
   input  logic            id_ex_alu_src,
   input  logic            id_ex_RegWrite,
   input  logic            id_ex_MemRead,
   input  logic            id_ex_MemWrite,
   input  logic [1:0]      forwardA,
   input  logic [1:0]      forwardB,
   input  logic [XLEN-1:0] mem_wb_wdata,
   input  logic            flush,
   output logic            ex_mem_valid,
   output logic [XLEN-1:0] ex_mem_alu_result,
   output logic [XLEN-1:0] ex_mem_store_data,
   output logic [4:0]      ex_mem_rd,
   output logic            ex_mem_RegWrite,
   output logic            ex_mem_MemRead,
   output logic            ex_mem_MemWrite,
   output logic            ex_stall
);

   alu_op_e               w_op;
   logic [XLEN-1:0]       w_op_a;
   logic [XLEN-1:0]       w_rs2_fwd;
   logic [XLEN-1:0]       w_op_b;
   logic [XLEN-1:0]       w_alu_result;
   logic [2*XLEN-1:0]     w_mul_a;
   logic [2*XLEN-1:0]     w_mul_b;
   logic [2*XLEN-1:0]     w_prod;
   logic                  w_is_div;
   logic                  w_start;
   logic                  w_div_run;
   logic                  w_div_done;
   logic                  w_div_idle;
   logic [XLEN-1:0]       w_div_result;
   logic [DIV_TAG_W-1:0]  w_div_tag;
   logic                  w_take_div;
   logic                  w_take_alu;

   assign w_op = alu_op_e'(id_ex_alu_op);

   // Operand forwarding; the unused encoding 11 falls back to the register file.
   always_comb begin
      w_op_a = id_ex_rs1_data;
      case (forwardA)
         FWD_MEM: w_op_a = ex_mem_alu_result;
         FWD_WB:  w_op_a = mem_wb_wdata;
         default: w_op_a = id_ex_rs1_data;
      endcase
   end

   always_comb begin
      w_rs2_fwd = id_ex_rs2_data;
      case (forwardB)
         FWD_MEM: w_rs2_fwd = ex_mem_alu_result;
         FWD_WB:  w_rs2_fwd = mem_wb_wdata;
         default: w_rs2_fwd = id_ex_rs2_data;
      endcase
   end

   assign w_op_b = id_ex_alu_src ? id_ex_imm : w_rs2_fwd;

   // A single 2*XLEN multiplier serves all four MUL ops: sign- or zero-extend
   // each operand, and the low 2*XLEN bits of the product are exact.
   assign w_mul_a = ((w_op == OP_MULH) || (w_op == OP_MULHSU))
                    ? {{XLEN{w_op_a[XLEN-1]}}, w_op_a} : {{XLEN{1'b0}}, w_op_a};
   assign w_mul_b = (w_op == OP_MULH)
                    ? {{XLEN{w_op_b[XLEN-1]}}, w_op_b} : {{XLEN{1'b0}}, w_op_b};
   assign w_prod  = w_mul_a * w_mul_b;

   always_comb begin
      w_alu_result = '0;
      case (w_op)
         OP_ADD:    w_alu_result = w_op_a + w_op_b;
         OP_SUB:    w_alu_result = w_op_a - w_op_b;
         OP_SLL:    w_alu_result = w_op_a << w_op_b[4:0];
         OP_SRL:    w_alu_result = w_op_a >> w_op_b[4:0];
         OP_SRA:    w_alu_result = $signed(w_op_a) >>> w_op_b[4:0];
         OP_SLT:    w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
         OP_SLTU:   w_alu_result = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
         OP_XOR:    w_alu_result = w_op_a ^ w_op_b;
         OP_OR:     w_alu_result = w_op_a | w_op_b;
         OP_AND:    w_alu_result = w_op_a & w_op_b;
         OP_PASSB:  w_alu_result = w_op_b;
         OP_MUL:    w_alu_result = w_prod[XLEN-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  w_alu_result = w_prod[2*XLEN-1:XLEN];
         default:   w_alu_result = '0;
      endcase
   end

   assign w_is_div = is_div_op(w_op);
   assign w_start  = id_ex_valid && w_is_div;

   ex_divider #(
      .XLEN     (XLEN),
      .DIV_ITER (DIV_ITER)
   ) u_divider (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_abort   (flush),
      .i_op      (w_op),
      .i_a       (w_op_a),
      .i_b       (w_op_b),
      .i_tag     ({id_ex_rd, id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite}),
      .o_running (w_div_run),
      .o_done    (w_div_done),
      .o_result  (w_div_result),
      .o_tag     (w_div_tag)
   );

   assign w_div_idle = !w_div_run && !w_div_done;

   // Stall from first sight of a divide until the divider reaches DONE. A
   // flush kills the divide this cycle, so the stall must drop with it.
   assign ex_stall = !rst && !flush && (w_div_run || (w_div_idle && w_start));

   assign w_take_div = w_div_done && !flush;
   assign w_take_alu = id_ex_valid && !flush && !w_div_done && !ex_stall && !w_is_div;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_mem_valid      <= 1'b0;
         ex_mem_alu_result <= '0;
         ex_mem_store_data <= '0;
         ex_mem_rd         <= '0;
         ex_mem_RegWrite   <= 1'b0;
         ex_mem_MemRead    <= 1'b0;
         ex_mem_MemWrite   <= 1'b0;
      end else begin
         ex_mem_store_data <= w_rs2_fwd;
         ex_mem_alu_result <= w_div_done ? w_div_result : w_alu_result;
         ex_mem_rd         <= w_div_done ? w_div_tag[7:3] : id_ex_rd;
         if (w_take_div) begin
            ex_mem_valid    <= 1'b1;
            ex_mem_RegWrite <= w_div_tag[2];
            ex_mem_MemRead  <= w_div_tag[1];
            ex_mem_MemWrite <= w_div_tag[0];
         end else if (w_take_alu) begin
            ex_mem_valid    <= 1'b1;
            ex_mem_RegWrite <= id_ex_RegWrite;
            ex_mem_MemRead  <= id_ex_MemRead;
            ex_mem_MemWrite <= id_ex_MemWrite;
         end else begin
            ex_mem_valid    <= 1'b0;
            ex_mem_RegWrite <= 1'b0;
            ex_mem_MemRead  <= 1'b0;
            ex_mem_MemWrite <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage. Expected values come from a behavioural
// model using 64-bit integer arithmetic; divides are timed by counting the
// cycles ex_stall stays high.
// ----------------------------------------------------------------------------
module tb_ex_stage;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_ex_valid;
   logic [31:0] id_ex_rs1_data;
   logic [31:0] id_ex_rs2_data;
   logic [31:0] id_ex_imm;
   logic [4:0]  id_ex_rd;
   logic [4:0]  id_ex_alu_op;
   logic        id_ex_alu_src;
   logic        id_ex_RegWrite;
   logic        id_ex_MemRead;
   logic        id_ex_MemWrite;
   logic [1:0]  forwardA;
   logic [1:0]  forwardB;
   logic [31:0] mem_wb_wdata;
   logic        flush;
   logic        ex_mem_valid;
   logic [31:0] ex_mem_alu_result;
   logic [31:0] ex_mem_store_data;
   logic [4:0]  ex_mem_rd;
   logic        ex_mem_RegWrite;
   logic        ex_mem_MemRead;
   logic        ex_mem_MemWrite;
   logic        ex_stall;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32), .DIV_ITER(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .id_ex_valid       (id_ex_valid),
      .id_ex_rs1_data    (id_ex_rs1_data),
      .id_ex_rs2_data    (id_ex_rs2_data),
      .id_ex_imm         (id_ex_imm),
      .id_ex_rd          (id_ex_rd),
      .id_ex_alu_op      (id_ex_alu_op),
      .id_ex_alu_src     (id_ex_alu_src),
      .id_ex_RegWrite    (id_ex_RegWrite),
      .id_ex_MemRead     (id_ex_MemRead),
      .id_ex_MemWrite    (id_ex_MemWrite),
      .forwardA          (forwardA),
      .forwardB          (forwardB),
      .mem_wb_wdata      (mem_wb_wdata),
      .flush             (flush),
      .ex_mem_valid      (ex_mem_valid),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_store_data (ex_mem_store_data),
      .ex_mem_rd         (ex_mem_rd),
      .ex_mem_RegWrite   (ex_mem_RegWrite),
      .ex_mem_MemRead    (ex_mem_MemRead),
      .ex_mem_MemWrite   (ex_mem_MemWrite),
      .ex_stall          (ex_stall)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = 0;
      case (op)
         OP_ADD:    return a + b;
         OP_SUB:    return a - b;
         OP_SLL:    return a << b[4:0];
         OP_SRL:    return a >> b[4:0];
         OP_SRA:    begin p = sa >>> b[4:0]; return p[31:0]; end
         OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
         OP_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
         OP_XOR:    return a ^ b;
         OP_OR:     return a | b;
         OP_AND:    return a & b;
         OP_PASSB:  return b;
         OP_MUL:    begin p = ua * ub; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV:    begin if (b == 32'h0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         OP_DIVU:   begin if (b == 32'h0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
         OP_REM:    begin if (b == 32'h0) return a; p = sa % sb; return p[31:0]; end
         OP_REMU:   begin if (b == 32'h0) return a; p = ua % ub; return p[31:0]; end
         default:   return 32'h0;
      endcase
   endfunction

   function automatic int model_div_stall(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      sgn = (op == OP_DIV) || (op == OP_REM);
      if (b == 32'h0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      id_ex_valid    = 1'b1;
      id_ex_alu_op   = op;
      id_ex_rs1_data = a;
      id_ex_rs2_data = b;
      id_ex_imm      = 32'h0;
      id_ex_alu_src  = 1'b0;
      id_ex_rd       = rd;
      id_ex_RegWrite = 1'b1;
      id_ex_MemRead  = 1'b0;
      id_ex_MemWrite = 1'b0;
      forwardA       = FWD_RF;
      forwardB       = FWD_RF;
      flush          = 1'b0;
   endtask

   task automatic bubble();
      id_ex_valid    = 1'b0;
      id_ex_RegWrite = 1'b0;
      id_ex_MemRead  = 1'b0;
      id_ex_MemWrite = 1'b0;
      forwardA       = FWD_RF;
      forwardB       = FWD_RF;
   endtask

   // Issue one divide, count stall cycles, check the bubbles and the result.
   task automatic run_div(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_stall,
                          input string name);
      int n;
      int bad;
      drive(op, a, b, rd);
      #1;
      n   = 0;
      bad = 0;
      while (ex_stall === 1'b1 && n < 40) begin
         step();
         n++;
         if (ex_mem_valid !== 1'b0 || ex_mem_RegWrite !== 1'b0) bad++;
      end
      n_checks++;
      if (n !== exp_stall) $display("FAIL %s_stall: got %0d stall cycles, expected %0d", name, n, exp_stall);
      else n_pass++;
      n_checks++;
      if (bad !== 0) $display("FAIL %s_bubbles: got %0d non-bubble entries, expected 0", name, bad);
      else n_pass++;
      step();
      bubble();
      $display("div %s op=%0d a=%h b=%h -> %h (stall %0d)", name, op, a, b, ex_mem_alu_result, n);
      n_checks++;
      if (ex_mem_alu_result !== exp_res)
         $display("FAIL %s_result: got %h expected %h", name, ex_mem_alu_result, exp_res);
      else n_pass++;
      n_checks++;
      if ({ex_mem_valid, ex_mem_rd, ex_mem_RegWrite} !== {1'b1, rd, 1'b1})
         $display("FAIL %s_ctrl: got valid=%b rd=%0d rw=%b expected 1/%0d/1", name,
                  ex_mem_valid, ex_mem_rd, ex_mem_RegWrite, rd);
      else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(OP_ADD, 32'd1, 32'd1, 5'd1);
      step();
      step();
      n_checks++;
      if ({ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_RegWrite,
           ex_mem_MemRead, ex_mem_MemWrite} !== '0)
         $display("FAIL reset_outputs: got valid=%b res=%h sd=%h rd=%0d ctl=%b%b%b expected all 0",
                  ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
                  ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite);
      else n_pass++;
      n_checks++;
      if (ex_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", ex_stall);
      else n_pass++;
      $display("reset: outputs cleared");
      rst = 1'b0;
      bubble();
   endtask

   task automatic test_forward();
      drive(OP_ADD, 32'd2, 32'd3, 5'd1);
      step();
      n_checks++;
      if (ex_mem_alu_result !== 32'd5) $display("FAIL add_rf: got %h expected 5", ex_mem_alu_result);
      else n_pass++;
      drive(OP_ADD, 32'd100, 32'd200, 5'd2);
      forwardA     = FWD_MEM;
      forwardB     = FWD_WB;
      mem_wb_wdata = 32'd7;
      step();
      $display("fwd add mem+wb -> %h", ex_mem_alu_result);
      n_checks++;
      if ({ex_mem_valid, ex_mem_alu_result} !== {1'b1, 32'd12})
         $display("FAIL fwd_add: got valid=%b res=%h expected 1/0000000c", ex_mem_valid, ex_mem_alu_result);
      else n_pass++;
      drive(OP_SUB, 32'd50, 32'd9, 5'd3);
      forwardA = 2'b11;
      forwardB = FWD_MEM;
      step();
      n_checks++;
      if (ex_mem_alu_result !== 32'd38) $display("FAIL fwd_sel11_sub: got %h expected 26", ex_mem_alu_result);
      else n_pass++;
      drive(OP_ADD, 32'd10, 32'd99, 5'd4);
      id_ex_alu_src = 1'b1;
      id_ex_imm     = 32'd5;
      forwardB      = FWD_WB;
      step();
      n_checks++;
      if ({ex_mem_alu_result, ex_mem_store_data} !== {32'd15, 32'd7})
         $display("FAIL imm_store: got res=%h sd=%h expected 0000000f/00000007",
                  ex_mem_alu_result, ex_mem_store_data);
      else n_pass++;
   endtask

   task automatic test_mul();
      drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
      step();
      $display("mulhu ffffffff*ffffffff -> %h", ex_mem_alu_result);
      n_checks++;
      if (ex_mem_alu_result !== 32'hFFFF_FFFE) $display("FAIL mulhu: got %h expected fffffffe", ex_mem_alu_result);
      else n_pass++;
      drive(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
      step();
      $display("mulh ffffffff*ffffffff -> %h", ex_mem_alu_result);
      n_checks++;
      if (ex_mem_alu_result !== 32'h0) $display("FAIL mulh: got %h expected 00000000", ex_mem_alu_result);
      else n_pass++;
   endtask

   task automatic test_random_alu();
      alu_op_e     op;
      logic        v, src, rw, mr, mw, prev_known;
      logic [1:0]  fa, fb;
      logic [4:0]  rd;
      logic [31:0] rs1, rs2, imm, wb, a, b2, bop, exp_res, prev;
      prev_known = 1'b0;
      prev       = 32'h0;
      for (int i = 0; i < 60; i++) begin
         op  = alu_op_e'(5'($urandom_range(0, 14)));
         v   = ($urandom_range(0, 7) != 0);
         rs1 = pick();
         rs2 = pick();
         imm = pick();
         wb  = pick();
         src = 1'($urandom_range(0, 1));
         rw  = 1'($urandom_range(0, 1));
         mr  = 1'($urandom_range(0, 1));
         mw  = 1'($urandom_range(0, 1));
         rd  = 5'($urandom_range(0, 31));
         fa  = 2'($urandom_range(0, 3));
         fb  = 2'($urandom_range(0, 3));
         if (!prev_known && fa == FWD_MEM) fa = FWD_RF;
         if (!prev_known && fb == FWD_MEM) fb = FWD_RF;
         a   = (fa == FWD_MEM) ? prev : (fa == FWD_WB) ? wb : rs1;
         b2  = (fb == FWD_MEM) ? prev : (fb == FWD_WB) ? wb : rs2;
         bop = src ? imm : b2;
         exp_res = model_alu(op, a, bop);
         id_ex_valid = v; id_ex_alu_op = op; id_ex_rs1_data = rs1; id_ex_rs2_data = rs2;
         id_ex_imm = imm; id_ex_alu_src = src; id_ex_rd = rd; id_ex_RegWrite = rw;
         id_ex_MemRead = mr; id_ex_MemWrite = mw; forwardA = fa; forwardB = fb;
         mem_wb_wdata = wb; flush = 1'b0;
         #1;
         n_checks++;
         if (ex_stall !== 1'b0) $display("FAIL rand_stall[%0d]: got %b expected 0", i, ex_stall);
         else n_pass++;
         step();
         $display("alu v=%b op=%0d a=%h b=%h -> %h", v, op, a, bop, ex_mem_alu_result);
         if (v) begin
            n_checks++;
            if (ex_mem_alu_result !== exp_res)
               $display("FAIL rand_result[%0d]: op=%0d got %h expected %h", i, op, ex_mem_alu_result, exp_res);
            else n_pass++;
            n_checks++;
            if (ex_mem_store_data !== b2)
               $display("FAIL rand_store[%0d]: got %h expected %h", i, ex_mem_store_data, b2);
            else n_pass++;
            n_checks++;
            if ({ex_mem_valid, ex_mem_rd, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite} !== {1'b1, rd, rw, mr, mw})
               $display("FAIL rand_ctrl[%0d]: got %b%b%b%b rd=%0d expected 1%b%b%b rd=%0d", i, ex_mem_valid,
                        ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite, ex_mem_rd, rw, mr, mw, rd);
            else n_pass++;
            prev       = exp_res;
            prev_known = 1'b1;
         end else begin
            n_checks++;
            if ({ex_mem_valid, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite} !== 4'b0000)
               $display("FAIL rand_bubble[%0d]: got %b%b%b%b expected 0000", i, ex_mem_valid,
                        ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite);
            else n_pass++;
            prev_known = 1'b0;
         end
      end
      bubble();
   endtask

   task automatic test_div_directed();
      run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_div(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, "rem_m7_2");
   endtask

   task automatic test_div_special();
      run_div(OP_DIVU, 32'd1234, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, "divu_by0");
      run_div(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0, 1, "rem_ovf");
      run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, "div_ovf");
      run_div(OP_REM, 32'hFFFF_FF00, 32'd0, 5'd11, 32'hFFFF_FF00, 1, "rem_by0");
   endtask

   task automatic test_div_random();
      alu_op_e     op;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         op = alu_op_e'(5'($urandom_range(15, 18)));
         a  = pick();
         b  = (i == 3) ? 32'h0 : (i % 2 == 0) ? pick() : 32'($urandom_range(1, 1000));
         run_div(op, a, b, 5'(i + 12), model_alu(op, a, b), model_div_stall(op, a, b), "div_rand");
      end
   endtask

   task automatic test_back_to_back();
      run_div(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33, "b2b_divu");
      drive(OP_ADD, 32'd0, 32'd1, 5'd4);
      forwardA = FWD_MEM;
      #1;
      n_checks++;
      if (ex_stall !== 1'b0) $display("FAIL b2b_stall: got %b expected 0", ex_stall);
      else n_pass++;
      step();
      $display("b2b add fwd(div)+1 -> %h", ex_mem_alu_result);
      n_checks++;
      if ({ex_mem_valid, ex_mem_alu_result} !== {1'b1, 32'd15})
         $display("FAIL b2b_add: got valid=%b res=%h expected 1/0000000f", ex_mem_valid, ex_mem_alu_result);
      else n_pass++;
      bubble();
   endtask

   task automatic test_flush();
      int bad;
      drive(OP_DIV, 32'd1000, 32'd3, 5'd5);
      repeat (11) step();
      flush = 1'b1;
      #1;
      n_checks++;
      if (ex_stall !== 1'b0) $display("FAIL flush_stall_drop: got %b expected 0", ex_stall);
      else n_pass++;
      step();
      flush = 1'b0;
      bubble();
      bad = 0;
      if (ex_mem_valid !== 1'b0 || ex_mem_RegWrite !== 1'b0) bad++;
      for (int i = 0; i < 40; i++) begin
         step();
         if (ex_mem_valid !== 1'b0 || ex_mem_RegWrite !== 1'b0 || ex_stall !== 1'b0) bad++;
      end
      $display("flush mid-divide: %0d unexpected entries", bad);
      n_checks++;
      if (bad !== 0) $display("FAIL flush_no_write: got %0d bad cycles expected 0", bad);
      else n_pass++;
      run_div(OP_DIVU, 32'd9, 32'd3, 5'd6, 32'd3, 33, "after_flush");
   endtask

   task automatic test_reset_mid_div();
      int bad;
      drive(OP_DIV, 32'd50, 32'd7, 5'd5);
      mem_wb_wdata = 32'h1234_5678;
      forwardB     = FWD_WB;
      repeat (5) step();
      rst = 1'b1;
      step();
      n_checks++;
      if ({ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_RegWrite,
           ex_mem_MemRead, ex_mem_MemWrite, ex_stall} !== '0)
         $display("FAIL rst_mid_div: got valid=%b res=%h sd=%h rd=%0d rw=%b stall=%b expected all 0",
                  ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_RegWrite, ex_stall);
      else n_pass++;
      rst = 1'b0;
      bubble();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (ex_mem_valid !== 1'b0 || ex_stall !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL rst_no_write: got %0d bad cycles expected 0", bad);
      else n_pass++;
      drive(OP_ADD, 32'd3, 32'd4, 5'd1);
      step();
      $display("add 3+4 after reset -> %h", ex_mem_alu_result);
      n_checks++;
      if ({ex_mem_valid, ex_mem_alu_result} !== {1'b1, 32'd7})
         $display("FAIL rst_then_add: got valid=%b res=%h expected 1/00000007", ex_mem_valid, ex_mem_alu_result);
      else n_pass++;
      bubble();
   endtask

   initial begin
      rst = 1'b1;
      mem_wb_wdata = 32'h0;
      flush = 1'b0;
      bubble();
      id_ex_alu_op = OP_ADD;
      id_ex_rs1_data = 32'h0;
      id_ex_rs2_data = 32'h0;
      id_ex_imm = 32'h0;
      id_ex_alu_src = 1'b0;
      id_ex_rd = 5'd0;
      test_reset();
      test_forward();
      test_mul();
      test_random_alu();
      test_div_directed();
      test_div_special();
      test_div_random();
      test_back_to_back();
      test_flush();
      test_reset_mid_div();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
